// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch path.
package fetch_pkg;
  localparam int              XLEN        = 32;
  localparam logic [XLEN-1:0] INSTR_NOP   = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INCR     = 32'd4;
  // pc[1:0] is the byte offset; word addresses start at bit WORD_LSB.
  localparam int              WORD_LSB    = 2;
  localparam int              WORD_ADDR_W = XLEN - WORD_LSB;
endpackage

// File: rtl/instruction_cache.sv
// Direct-mapped, one-word-per-line instruction cache; a miss stalls MISS_LATENCY cycles,
// then the line is written from mem_dat_i. Compiled only when FETCH_CACHE_EN is defined.
`ifdef FETCH_CACHE_EN
module instruction_cache
  import fetch_pkg::*;
#(
  parameter int CACHE_LINES  = 16,
  parameter int MISS_LATENCY = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] mem_dat_i,
  output logic            hit_o,
  output logic [XLEN-1:0] instr_o
);
  localparam int               IDX_W    = $clog2(CACHE_LINES);
  localparam int               TAG_W    = WORD_ADDR_W - IDX_W;
  localparam int               CNT_W    = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MISS_LATENCY - 1);

  logic [CACHE_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q  [CACHE_LINES];
  logic [XLEN-1:0]        data_q [CACHE_LINES];
  logic [CNT_W-1:0]       fill_cnt_q, fill_cnt_d;
  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       tag;
  logic                   fill_done;
  logic [WORD_LSB-1:0]    unused_byte_ofs;

  assign idx             = pc_i[IDX_W+WORD_LSB-1:WORD_LSB];
  assign tag             = pc_i[XLEN-1:IDX_W+WORD_LSB];
  assign unused_byte_ofs = pc_i[WORD_LSB-1:0];

  assign hit_o     = valid_q[idx] && (tag_q[idx] == tag);
  assign instr_o   = hit_o ? data_q[idx] : INSTR_NOP;
  assign fill_done = !hit_o && (fill_cnt_q == CNT_LAST);

  always_comb begin
    valid_d    = valid_q;
    fill_cnt_d = fill_cnt_q;
    if (fill_done) begin
      valid_d[idx] = 1'b1;
      fill_cnt_d   = '0;
    end else if (!hit_o) begin
      fill_cnt_d = fill_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      fill_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  // Tag/data carry no reset: valid_q gates every use of them.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= mem_dat_i;
    end
  end
endmodule
`endif

// File: rtl/fetch_module.sv
// Instruction fetch: PC register, read-only instruction memory, optional cache.
// Define FETCH_CACHE_EN to insert instruction_cache; otherwise memory is read at pc every cycle.
module fetch_module
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC      = 32'h0000_0000,
  parameter int              MEM_WORDS     = 1024,
  parameter int              CACHE_LINES   = 16,
  parameter int              MISS_LATENCY  = 4,
  parameter string           MEM_INIT_FILE = "instructions.mem"
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] branch_target,
  input  logic            pc_src,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pc,
  output logic            hit
);
  localparam int MEM_AW = $clog2(MEM_WORDS);

  logic [XLEN-1:0]     mem [MEM_WORDS];
  logic [XLEN-1:0]     pc_q, pc_d, mem_dat;
  logic [MEM_AW-1:0]   mem_addr;
  logic [WORD_LSB-1:0] unused_target_ofs;

  // Default image tags each word with its index.
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = {16'hC0DE, 16'(i)};
  end

  assign mem_addr          = pc_q[MEM_AW+WORD_LSB-1:WORD_LSB];
  assign mem_dat           = mem[mem_addr];
  assign unused_target_ofs = branch_target[WORD_LSB-1:0];

  assign pc_d = pc_src ? {branch_target[XLEN-1:WORD_LSB], {WORD_LSB{1'b0}}}
                       : pc_q + PC_INCR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   pc_q <= RESET_PC;
    else if (hit) pc_q <= pc_d;
  end

  assign pc = pc_q;

`ifdef FETCH_CACHE_EN
  instruction_cache #(
    .CACHE_LINES (CACHE_LINES),
    .MISS_LATENCY(MISS_LATENCY)
  ) u_icache (
    .clk      (clk),
    .rst_n    (rst_n),
    .pc_i     (pc_q),
    .mem_dat_i(mem_dat),
    .hit_o    (hit),
    .instr_o  (instruction)
  );
`else
  localparam int unused_cache_cfg = CACHE_LINES + MISS_LATENCY;
  assign hit         = 1'b1;
  assign instruction = mem_dat;
`endif
endmodule

// File: tb/tb_fetch_module.sv
// Self-checking bench for fetch_module; covers cached or uncached build depending on FETCH_CACHE_EN.
module tb_fetch_module;
  localparam int MEM_WORDS = 1024;
`ifdef FETCH_CACHE_EN
  localparam int MISS = 4;
`else
  localparam int MISS = 0;
`endif

  typedef struct {
    logic        src;
    logic [31:0] bt;
    logic [31:0] exp_pc;
    int          exp_stall;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          stall;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] branch_target;
  logic        pc_src;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        hit;

  int   vec_cnt = 0;
  int   err_cnt = 0;
  exp_t sb[$];
  vec_t tbl[$];

  fetch_module #(
    .RESET_PC     (32'h0000_0000),
    .MEM_WORDS    (MEM_WORDS),
    .CACHE_LINES  (16),
    .MISS_LATENCY (4),
    .MEM_INIT_FILE("")
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .branch_target(branch_target),
    .pc_src       (pc_src),
    .instruction  (instruction),
    .pc           (pc),
    .hit          (hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [31:0] w;
    w = (a >> 2) & (MEM_WORDS - 1);
    return 32'hC0DE_0000 | w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Waits (bounded) for hit, checking pc holds and NOP is shown while stalled,
  // then compares against the scoreboard and applies the vector's redirect.
  task automatic do_fetch(input vec_t v);
    exp_t e;
    int   stall;
    sb.push_back('{v.exp_pc, exp_word(v.exp_pc), v.exp_stall});
    stall = 0;
    while (hit !== 1'b1 && stall < 20) begin
      check32("stall_pc_hold", pc, v.exp_pc);
      check32("stall_nop", instruction, 32'h0);
      pc_src        = 1'b1;
      branch_target = 32'h0000_0F13;
      tick();
      stall++;
    end
    e = sb.pop_front();
    check32("hit_seen", {31'b0, hit}, 32'h1);
    check32("stall_len", 32'(stall), 32'(e.stall));
    check32("pc", pc, e.pc);
    check32("instruction", instruction, e.instr);
    pc_src        = v.src;
    branch_target = v.bt;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    pc_src        = 1'b0;
    branch_target = 32'h0;
    repeat (2) tick();
    check32("reset_pc", pc, 32'h0);
`ifdef FETCH_CACHE_EN
    check32("reset_hit", {31'b0, hit}, 32'h0);
    check32("reset_instr", instruction, 32'h0);
`else
    check32("reset_hit", {31'b0, hit}, 32'h1);
    check32("reset_instr", instruction, exp_word(32'h0));
`endif
    rst_n = 1'b1;

`ifdef FETCH_CACHE_EN
    tbl.push_back('{1'b0, 32'h0,         32'h0000_0000, MISS}); // cold miss at reset pc
    tbl.push_back('{1'b0, 32'h0,         32'h0000_0004, MISS});
    tbl.push_back('{1'b0, 32'h0,         32'h0000_0008, MISS});
    tbl.push_back('{1'b1, 32'h0,         32'h0000_000C, MISS});
    tbl.push_back('{1'b0, 32'h0,         32'h0000_0000, 0});    // warm rerun
    tbl.push_back('{1'b0, 32'h0,         32'h0000_0004, 0});
    tbl.push_back('{1'b0, 32'h0,         32'h0000_0008, 0});
    tbl.push_back('{1'b1, 32'h0000_0043, 32'h0000_000C, 0});
    tbl.push_back('{1'b1, 32'h0,         32'h0000_0040, MISS}); // evicts 0x00
    tbl.push_back('{1'b0, 32'h0,         32'h0000_0000, MISS}); // conflict miss
    tbl.push_back('{1'b1, 32'hFFFF_FFFC, 32'h0000_0004, 0});
    tbl.push_back('{1'b0, 32'h0,         32'hFFFF_FFFC, MISS}); // aliased memory word
    tbl.push_back('{1'b0, 32'h0,         32'h0000_0000, 0});    // pc wrapped
    tbl.push_back('{1'b1, 32'h0000_0200, 32'h0000_0004, 0});
`else
    tbl.push_back('{1'b0, 32'h0,         32'h0000_0000, 0});
    tbl.push_back('{1'b0, 32'h0,         32'h0000_0004, 0});
    tbl.push_back('{1'b1, 32'h0000_0043, 32'h0000_0008, 0});
    tbl.push_back('{1'b1, 32'hFFFF_FFFC, 32'h0000_0040, 0});
    tbl.push_back('{1'b0, 32'h0,         32'hFFFF_FFFC, 0});
    tbl.push_back('{1'b0, 32'h0,         32'h0000_0000, 0});
    tbl.push_back('{1'b1, 32'h0000_0200, 32'h0000_0004, 0});
`endif
    for (int i = 0; i < tbl.size(); i++) do_fetch(tbl[i]);

    // Reset asserted in the middle of the fill for 0x200.
    check32("pre_reset_pc", pc, 32'h0000_0200);
`ifdef FETCH_CACHE_EN
    check32("pre_reset_miss", {31'b0, hit}, 32'h0);
`else
    check32("pre_reset_instr", instruction, exp_word(32'h0000_0200));
`endif
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check32("midfill_reset_pc", pc, 32'h0);
`ifdef FETCH_CACHE_EN
    check32("midfill_reset_hit", {31'b0, hit}, 32'h0);
    check32("midfill_reset_instr", instruction, 32'h0);
`else
    check32("midfill_reset_hit", {31'b0, hit}, 32'h1);
`endif
    tick();
    rst_n = 1'b1;
    do_fetch('{1'b1, 32'h0000_0200, 32'h0000_0000, MISS});
    do_fetch('{1'b0, 32'h0,         32'h0000_0200, MISS});
    do_fetch('{1'b0, 32'h0,         32'h0000_0204, MISS});

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
